// File: rtl/stats_uart_tx_pkg.sv
// Shared types and constants for the stats telemetry transmitter.
// STATS_TX_CHECKSUM_EN selects whether the byte mux carries the XOR checksum byte.
package stats_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_BYTE   = 2'd2,
    ST_FINISH = 2'd3
  } tx_state_e;

  localparam logic [7:0]  STATS_SYNC_BYTE = 8'hA5;
  localparam int unsigned PKT_LEN_CSUM    = 6;
  localparam int unsigned PKT_LEN_NO_CSUM = 5;
  localparam int unsigned STAT_W          = 4;
  localparam int unsigned STATUS_W        = 7;
  localparam int unsigned BYTE_IDX_W      = 3;

  typedef struct packed {
    logic [STAT_W-1:0]   hunger;
    logic [STAT_W-1:0]   happiness;
    logic [STAT_W-1:0]   health;
    logic [STAT_W-1:0]   hygiene;
    logic [STAT_W-1:0]   energy;
    logic [STAT_W-1:0]   social;
    logic [STATUS_W-1:0] status;
  } stats_pkt_t;

  // Byte idx of the packet built from a snapshot.
  function automatic logic [7:0] pkt_byte(input stats_pkt_t p, input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: b = STATS_SYNC_BYTE;
      3'd1: b = {p.hunger, p.happiness};
      3'd2: b = {p.health, p.hygiene};
      3'd3: b = {p.energy, p.social};
      3'd4: b = {1'b0, p.status};
`ifdef STATS_TX_CHECKSUM_EN
      3'd5: b = {p.hunger, p.happiness} ^ {p.health, p.hygiene} ^
                {p.energy, p.social} ^ {1'b0, p.status};
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first. A start accepted during the final stop-bit
// cycle chains the next frame with no idle gap; byte_done marks that cycle.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    STOP_IDX = 4'd9;

  logic          active, active_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    idx, idx_n;
  logic [8:0]    shreg, shreg_n;
  logic          tx_n;
  logic          last_c;

  // Next-state for baud counter, bit index and shift register.
  always_comb begin
    active_n = active;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    tx_n     = tx;
    last_c   = active && (idx == STOP_IDX) && (cnt == CNT_MAX);
    if (start && (!active || last_c)) begin
      active_n = 1'b1;
      cnt_n    = '0;
      idx_n    = '0;
      shreg_n  = {1'b1, data};
      tx_n     = 1'b0;
    end else if (active) begin
      if (cnt == CNT_MAX) begin
        cnt_n = '0;
        if (idx == STOP_IDX) begin
          active_n = 1'b0;
          tx_n     = 1'b1;
        end else begin
          idx_n   = idx + 4'd1;
          tx_n    = shreg[0];
          shreg_n = {1'b1, shreg[8:1]};
        end
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '1;
      tx        <= 1'b1;
      ready     <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      active    <= active_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
      ready     <= !active_n;
      byte_done <= active_n && (idx_n == STOP_IDX) && (cnt_n == CNT_MAX);
    end
  end

endmodule

// File: rtl/stats_uart_tx.sv
// Telemetry packet transmitter: snapshots six stats plus status and sends them
// as a sync-prefixed UART packet. STATS_TX_CHECKSUM_EN appends an XOR checksum.
module stats_uart_tx
  import stats_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned SEND_PERIOD  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                send,
  input  logic [STAT_W-1:0]   hunger,
  input  logic [STAT_W-1:0]   happiness,
  input  logic [STAT_W-1:0]   health,
  input  logic [STAT_W-1:0]   hygiene,
  input  logic [STAT_W-1:0]   energy,
  input  logic [STAT_W-1:0]   social,
  input  logic [STATUS_W-1:0] status,
  output logic                uart_tx,
  output logic                busy,
  output logic                done
);

`ifdef STATS_TX_CHECKSUM_EN
  localparam int unsigned PKT_LEN = PKT_LEN_CSUM;
`else
  localparam int unsigned PKT_LEN = PKT_LEN_NO_CSUM;
`endif
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(PKT_LEN - 1);

  tx_state_e               state;
  stats_pkt_t              pkt;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  logic [BYTE_IDX_W-1:0]   send_idx_c;
  logic [7:0]              byte_c;
  logic                    pending;
  logic                    tick_c;
  logic                    pkt_start_c;
  logic                    start_c;
  logic                    ser_ready;
  logic                    ser_done;

  // Free-running auto-send period counter, independent of busy.
  if (SEND_PERIOD != 0) begin : g_period
    localparam int unsigned PW = (SEND_PERIOD > 2) ? $clog2(SEND_PERIOD) : 1;
    logic [PW-1:0] period_cnt;

    assign tick_c = (period_cnt == PW'(SEND_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      period_cnt <= '0;
      else if (tick_c) period_cnt <= '0;
      else             period_cnt <= period_cnt + PW'(1);
    end
  end else begin : g_no_period
    assign tick_c = 1'b0;
  end

  // Serialiser start: first byte from LOAD, later bytes chained on byte_done.
  always_comb begin
    pkt_start_c = pending && ((state == ST_IDLE) || (state == ST_FINISH));
    start_c     = 1'b0;
    send_idx_c  = byte_idx;
    if (state == ST_LOAD) begin
      start_c    = ser_ready;
      send_idx_c = '0;
    end else if ((state == ST_BYTE) && ser_done && (byte_idx != LAST_IDX)) begin
      start_c    = 1'b1;
      send_idx_c = byte_idx + BYTE_IDX_W'(1);
    end
    byte_c = pkt_byte(pkt, send_idx_c);
  end

  // Packet sequencer; set wins over clear so a request on the start cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pkt      <= '0;
      byte_idx <= '0;
      pending  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pending <= (pending && !pkt_start_c) || send || tick_c;
      done    <= 1'b0;
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (pkt_start_c) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            byte_idx <= '0;
            pkt      <= {hunger, happiness, health, hygiene, energy, social, status};
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (ser_ready) state <= ST_BYTE;
        end
        ST_BYTE: begin
          if (ser_done) begin
            if (byte_idx == LAST_IDX) begin
              state <= ST_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              byte_idx <= byte_idx + BYTE_IDX_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_c),
    .data      (byte_c),
    .tx        (uart_tx),
    .ready     (ser_ready),
    .byte_done (ser_done)
  );

endmodule

// File: tb/tb_stats_uart_tx.sv
// Bench for stats_uart_tx: decodes the serial line and compares against a packet
// model built from the stat inputs; follows STATS_TX_CHECKSUM_EN for packet length.
module tb_stats_uart_tx;

  localparam int C      = 4;
  localparam int PERIOD = 300;
`ifdef STATS_TX_CHECKSUM_EN
  localparam int PKT_LEN = 6;
`else
  localparam int PKT_LEN = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n, rp_n;
  logic       send;
  logic       send_p;
  logic [3:0] hunger, happiness, health, hygiene, energy, social;
  logic [6:0] status;
  logic       uart_tx, busy, done;
  logic       tx_p, busy_p, done_p;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int r0 = 0;
  logic busy_p_q = 1'b0;
  int rise_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy_p === 1'b1 && busy_p_q !== 1'b1) rise_q.push_back(cyc);
    busy_p_q <= busy_p;
  end

  stats_uart_tx #(.CLKS_PER_BIT(C), .SEND_PERIOD(0)) dut (
    .clk(clk), .rst_n(rst_n), .send(send),
    .hunger(hunger), .happiness(happiness), .health(health), .hygiene(hygiene),
    .energy(energy), .social(social), .status(status),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  stats_uart_tx #(.CLKS_PER_BIT(C), .SEND_PERIOD(PERIOD)) dut_p (
    .clk(clk), .rst_n(rp_n), .send(send_p),
    .hunger(hunger), .happiness(happiness), .health(health), .hygiene(hygiene),
    .energy(energy), .social(social), .status(status),
    .uart_tx(tx_p), .busy(busy_p), .done(done_p)
  );

  // Packet model: sync, three stat-pair bytes, status, optional XOR of bytes 1..4.
  function automatic void build_expected();
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({hunger, happiness});
    exp_q.push_back({health, hygiene});
    exp_q.push_back({energy, social});
    exp_q.push_back({1'b0, status});
    if (PKT_LEN == 6) begin
      x = 8'h00;
      for (int i = 1; i <= 4; i++) x = x ^ exp_q[i];
      exp_q.push_back(x);
    end
  endfunction

  function automatic logic line_of(input bit p);
    return p ? tx_p : uart_tx;
  endfunction

  function automatic void randomize_stats();
    hunger    = 4'($urandom);
    happiness = 4'($urandom);
    health    = 4'($urandom);
    hygiene   = 4'($urandom);
    energy    = 4'($urandom);
    social    = 4'($urandom);
    status    = 7'($urandom);
  endfunction

  // Called on a negedge; looks for a start bit, then samples each bit mid-period.
  task automatic rx_byte(input bit p, input int limit, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < limit; i++) begin
      if (line_of(p) === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      repeat (C / 2) @(negedge clk);
      if (line_of(p) !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (C) @(negedge clk);
        b[j] = line_of(p);
      end
      repeat (C) @(negedge clk);
      if (line_of(p) !== 1'b1) ok = 1'b0;
    end
  endtask

  // Drives (or inherits) a request, decodes the packet and checks latency and done.
  task automatic run_packet(input string tag, input bit do_send, input int zero_at, input int extra_sends);
    int n;
    logic [7:0] b;
    bit ok;
    build_expected();
    if (do_send) begin
      @(negedge clk);
      n = cyc + 1;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end else begin
      n = cyc;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_before_load got=%b exp=0", tag, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || uart_tx !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s load_cycle busy=%b tx=%b done=%b exp busy=1 tx=1 done=0", tag, busy, uart_tx, done);
    end
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0) begin
      failures++;
      $display("FAIL %s start_bit_latency tx=%b exp=0", tag, uart_tx);
    end
    fork
      begin
        for (int i = 0; i < PKT_LEN; i++) begin
          rx_byte(1'b0, (i == 0) ? 1 : 4, b, ok);
          checks++;
          if (!ok || b !== exp_q[i]) begin
            failures++;
            $display("FAIL %s byte%0d got=%h framed=%0d exp=%h", tag, i, b, ok, exp_q[i]);
          end
          if (i + 1 == zero_at) begin
            hunger = 0; happiness = 0; health = 0; hygiene = 0;
            energy = 0; social = 0; status = 0;
          end
        end
      end
      begin
        for (int k = 0; k < extra_sends; k++) begin
          repeat ($urandom_range(5, 40)) @(negedge clk);
          send = 1'b1;
          @(negedge clk);
          send = 1'b0;
        end
      end
    join
    repeat (C / 2 - 1) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s pre_done done=%b busy=%b exp done=0 busy=1", tag, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cyc != n + 2 + 10 * C * PKT_LEN) begin
      failures++;
      $display("FAIL %s done_pulse done=%b busy=%b at=%0d exp done=1 busy=0 at=%0d",
               tag, done, busy, cyc - n, 2 + 10 * C * PKT_LEN);
    end
  endtask

  task automatic check_done_low(input string tag);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1) begin
      failures++;
      $display("FAIL %s after_done done=%b busy=%b tx=%b exp 0 0 1", tag, done, busy, uart_tx);
    end
  endtask

  task automatic test_reset();
    int bad_tx, bad_busy, bad_done;
    rst_n = 1'b1; rp_n = 1'b1; send = 1'b0; send_p = 1'b0;
    randomize_stats();
    #3;
    rst_n = 1'b0; rp_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values tx=%b busy=%b done=%b exp 1 0 0", uart_tx, busy, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rp_n = 1'b1;
    r0 = cyc;
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_tx != 0) begin failures++; $display("FAIL idle_tx cycles_low=%0d exp=0", bad_tx); end
    checks++;
    if (bad_busy != 0) begin failures++; $display("FAIL idle_busy cycles_high=%0d exp=0", bad_busy); end
    checks++;
    if (bad_done != 0) begin failures++; $display("FAIL idle_done pulses=%0d exp=0", bad_done); end
  endtask

  task automatic test_directed();
    hunger = 4'h3; happiness = 4'hA; health = 4'hF; hygiene = 4'h0;
    energy = 4'h5; social = 4'hC; status = 7'h41;
    run_packet("directed", 1'b1, 0, 0);
    check_done_low("directed");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      randomize_stats();
      run_packet("random", 1'b1, 0, 0);
      check_done_low("random");
    end
  endtask

  task automatic test_snapshot();
    randomize_stats();
    run_packet("snapshot", 1'b1, 3, 0);
    check_done_low("snapshot");
  endtask

  task automatic test_back_to_back();
    int d0;
    int bad_tx;
    randomize_stats();
    @(negedge clk);
    #1;
    d0 = done_cnt;
    run_packet("b2b_first", 1'b1, 0, 3);
    run_packet("b2b_second", 1'b0, 0, 0);
    check_done_low("b2b_second");
    bad_tx = 0;
    for (int i = 0; i < 20 * C * PKT_LEN; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad_tx++;
    end
    #1;
    checks++;
    if (done_cnt - d0 != 2 || bad_tx != 0) begin
      failures++;
      $display("FAIL b2b_packet_count packets=%0d active_cycles_after=%0d exp packets=2 active=0",
               done_cnt - d0, bad_tx);
    end
  endtask

  task automatic test_period_and_reset();
    int rel, t_start;
    bit found;
    logic [7:0] b;
    bit ok;
    for (int i = 0; i < 1000 && rise_q.size() < 3; i++) @(negedge clk);
    checks++;
    if (rise_q.size() < 3) begin
      failures++;
      $display("FAIL period_rises got=%0d exp>=3", rise_q.size());
    end else begin
      checks++;
      if (rise_q[0] != r0 + PERIOD + 1) begin
        failures++;
        $display("FAIL period_first_start got=%0d exp=%0d", rise_q[0] - r0, PERIOD + 1);
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rise_q[i] - rise_q[i-1] != PERIOD) begin
          failures++;
          $display("FAIL period_interval%0d got=%0d exp=%0d", i, rise_q[i] - rise_q[i-1], PERIOD);
        end
      end
    end
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (busy_p === 1'b1) begin found = 1'b1; break; end
    end
    repeat (10 * C + 5) @(negedge clk);
    #2;
    rp_n = 1'b0;
    #1;
    checks++;
    if (!found || tx_p !== 1'b1 || busy_p !== 1'b0 || done_p !== 1'b0) begin
      failures++;
      $display("FAIL midpacket_reset seen_busy=%0d tx=%b busy=%b done=%b exp 1 1 0 0", found, tx_p, busy_p, done_p);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tx_p !== 1'b1 || busy_p !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold tx=%b busy=%b exp 1 0", tx_p, busy_p);
    end
    randomize_stats();
    build_expected();
    rise_q.delete();
    rp_n = 1'b1;
    rel = cyc;
    found = 1'b0;
    t_start = 0;
    for (int i = 0; i < PERIOD + 100; i++) begin
      @(negedge clk);
      if (tx_p === 1'b0) begin found = 1'b1; t_start = cyc; break; end
    end
    checks++;
    if (!found || t_start != rel + PERIOD + 2) begin
      failures++;
      $display("FAIL post_reset_start found=%0d at=%0d exp at=%0d", found, t_start - rel, PERIOD + 2);
    end
    for (int i = 0; i < PKT_LEN; i++) begin
      rx_byte(1'b1, 4, b, ok);
      checks++;
      if (!ok || b !== exp_q[i]) begin
        failures++;
        $display("FAIL post_reset_byte%0d got=%h framed=%0d exp=%h", i, b, ok, exp_q[i]);
      end
    end
    checks++;
    if (rise_q.size() < 1 || rise_q[0] != rel + PERIOD + 1) begin
      failures++;
      $display("FAIL post_reset_busy_rise n=%0d at=%0d exp at=%0d", rise_q.size(),
               (rise_q.size() > 0) ? rise_q[0] - rel : -1, PERIOD + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_snapshot();
    test_back_to_back();
    test_period_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
